// File: rtl/rr_mux_n.sv
// rr_mux_n: N-to-1 round-robin selector feeding a one-entry registered output buffer.
// Define RR_MUX_LOCK_EN to add the in_last port and hold the grant for a whole burst.
module rr_mux_n #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_ok;
    logic             req;
    logic             found;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] sel_ch;
    logic [SEL_W-1:0] sel_next;
    logic [SEL_W-1:0] scan_idx;
    int               scan_sum;

    assign load_ok = !out_valid_q || out_ready;

    // Scan from ptr upward, wrapping explicitly so non-power-of-2 channel counts work.
    always_comb begin : arbiter
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        scan_sum = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_sum = int'(ptr_q) + k;
            if (scan_sum >= CHANNELS) begin
                scan_sum = scan_sum - CHANNELS;
            end
            scan_idx = SEL_W'(scan_sum);
            if (!found && in_valid[scan_idx]) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;

    // A locked burst owns the port; a gap on its channel loads nothing.
    assign sel_ch = lock_q ? lock_ch_q : grant;
    assign req    = lock_q ? in_valid[lock_ch_q] : found;
`else
    assign sel_ch = grant;
    assign req    = found;
`endif

    assign sel_next = (int'(sel_ch) == CHANNELS - 1) ? '0 : sel_ch + SEL_W'(1);

    always_comb begin : ready_gen
        in_ready = '0;
        if (load_ok && req && !reset) begin
            in_ready[sel_ch] = 1'b1;
        end
    end

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
`ifdef RR_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (load_ok) begin
            if (req) begin
                out_data_d  = in_data[int'(sel_ch)*WIDTH +: WIDTH];
                out_sel_d   = sel_ch;
                out_valid_d = 1'b1;
                ptr_d       = sel_next;
`ifdef RR_MUX_LOCK_EN
                if (!in_last[sel_ch]) begin
                    lock_d    = 1'b1;
                    lock_ch_d = sel_ch;
                    ptr_d     = ptr_q;
                end else begin
                    lock_d    = 1'b0;
                end
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef RR_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef RR_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed stimulus with a queue-based scoreboard on the 8-channel instance
// and direct checks on a 5-channel instance for non-power-of-2 wrap.
module tb_rr_mux_n;

    logic clock = 1'b0;
    logic reset;

    logic [8*32-1:0] in_data8;
    logic [7:0]      in_valid8, in_ready8, in_last8;
    logic [31:0]     out_data8;
    logic [2:0]      out_sel8;
    logic            out_valid8, out_ready8;

    logic [5*16-1:0] in_data5;
    logic [4:0]      in_valid5, in_ready5, in_last5;
    logic [15:0]     out_data5;
    logic [2:0]      out_sel5;
    logic            out_valid5, out_ready5;

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_q[$];
    logic [34:0] mon_exp;

    always #5 clock = ~clock;

    rr_mux_n #(.WIDTH(32), .CHANNELS(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
`ifdef RR_MUX_LOCK_EN
        .in_last(in_last8),
`endif
        .out_data(out_data8), .out_sel(out_sel8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    rr_mux_n #(.WIDTH(16), .CHANNELS(5)) dut5 (
        .clock(clock), .reset(reset),
        .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
`ifdef RR_MUX_LOCK_EN
        .in_last(in_last5),
`endif
        .out_data(out_data5), .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every word leaving the buffer must match the next expected entry.
    always @(negedge clock) begin
        if (!reset && out_valid8 && out_ready8) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual sel=%0d data=%0h required=none", out_sel8, out_data8);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("sb_sel", 64'(out_sel8), 64'(mon_exp[34:32]));
                chk("sb_data", 64'(out_data8), 64'(mon_exp[31:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_valid8  = '1;
        in_data8   = '0;
        in_last8   = '1;
        out_ready8 = 1'b1;
        in_valid5  = '0;
        in_data5   = '0;
        in_last5   = '1;
        out_ready5 = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_out_valid", 64'(out_valid8), 64'd0);
        chk("reset_out_data", 64'(out_data8), 64'd0);
        chk("reset_out_sel", 64'(out_sel8), 64'd0);
        chk("reset_in_ready", 64'(in_ready8), 64'd0);

        // Fairness: all channels valid, one transfer per cycle in order 0..7,0,1.
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = 32'h100 + i;
        in_valid8 = '1;
        reset     = 1'b0;
        for (int n = 0; n < 10; n++) exp_q.push_back({3'(n % 8), 32'(256 + n % 8)});
        for (int n = 0; n < 10; n++) begin
            @(posedge clock); #1;
            if (n == 9) in_valid8 = '0;
            @(negedge clock);
            chk("thru_sel", 64'(out_sel8), 64'(n % 8));
        end

        // Empty: buffer drains one edge after requests stop.
        @(posedge clock); #1;
        @(negedge clock);
        chk("empty_out_valid", 64'(out_valid8), 64'd0);
        chk("empty_in_ready", 64'(in_ready8), 64'd0);

        // Backpressure: ch2 held for five stalled cycles, then drain and reload together.
        @(posedge clock); #1;
        out_ready8 = 1'b0;
        in_valid8  = '1;
        for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = 32'h200 + i;
        exp_q.push_back({3'd2, 32'h202});
        @(posedge clock);
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk("bp_in_ready", 64'(in_ready8), 64'd0);
            chk("bp_hold_data", 64'(out_data8), 64'h202);
            chk("bp_hold_sel", 64'(out_sel8), 64'd2);
            @(posedge clock);
        end
        #1;
        out_ready8 = 1'b1;
        exp_q.push_back({3'd3, 32'h203});
        @(negedge clock);
        chk("bp_resume_ready", 64'(in_ready8), 64'h08);
        @(posedge clock); #1;
        in_valid8 = '0;
        @(negedge clock);
        chk("bp_reload_sel", 64'(out_sel8), 64'd3);
        chk("bp_reload_valid", 64'(out_valid8), 64'd1);
        @(posedge clock); #1;

        // Mid-stream reset with a word buffered (ptr=4, only ch6 valid).
        out_ready8 = 1'b0;
        in_valid8  = 8'h40;
        in_data8[6*32 +: 32] = 32'h306;
        @(posedge clock);
        @(negedge clock);
        chk("pre_reset_sel", 64'(out_sel8), 64'd6);
        chk("pre_reset_valid", 64'(out_valid8), 64'd1);
        #2;
        reset      = 1'b1;
        out_ready8 = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_out_data", 64'(out_data8), 64'd0);
        chk("rst_out_sel", 64'(out_sel8), 64'd0);
        chk("rst_in_ready", 64'(in_ready8), 64'd0);
        in_valid8 = 8'h21;
        in_data8[0*32 +: 32] = 32'h400;
        in_data8[5*32 +: 32] = 32'h405;
        exp_q.push_back({3'd0, 32'h400});
        exp_q.push_back({3'd5, 32'h405});
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        in_valid8 = 8'h20;
        @(posedge clock); #1;
        in_valid8 = '0;
        @(posedge clock); #1;

`ifdef RR_MUX_LOCK_EN
        // Lock: ch2 burst of three with a one-cycle gap; ch3 waits throughout (ptr=6).
        in_valid8 = 8'h0C;
        in_last8  = '0;
        in_data8[2*32 +: 32] = 32'h500;
        in_data8[3*32 +: 32] = 32'h533;
        exp_q.push_back({3'd2, 32'h500});
        @(posedge clock); #1;
        in_data8[2*32 +: 32] = 32'h501;
        exp_q.push_back({3'd2, 32'h501});
        @(posedge clock); #1;
        in_valid8 = 8'h08;
        @(negedge clock);
        chk("lock_gap_ready", 64'(in_ready8), 64'd0);
        @(posedge clock); #1;
        in_valid8 = 8'h0C;
        in_data8[2*32 +: 32] = 32'h502;
        in_last8[2] = 1'b1;
        exp_q.push_back({3'd2, 32'h502});
        @(negedge clock);
        chk("lock_last_ready", 64'(in_ready8), 64'h04);
        @(posedge clock); #1;
        in_valid8 = 8'h08;
        exp_q.push_back({3'd3, 32'h533});
        @(posedge clock); #1;
        in_valid8 = '0;
        in_last8  = '1;
        @(posedge clock); #1;
`endif

        // Non-power-of-2 wrap on the 5-channel instance.
        for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'h50 + 16'(i);
        in_valid5 = 5'b01000;
        @(posedge clock); #1;
        in_valid5 = 5'b01010;
        @(negedge clock);
        chk("w5_first_sel", 64'(out_sel5), 64'd3);
        chk("w5_ready_ch1", 64'(in_ready5), 64'h02);
        @(posedge clock);
        @(negedge clock);
        chk("w5_wrap_sel", 64'(out_sel5), 64'd1);
        chk("w5_wrap_data", 64'(out_data5), 64'h51);
        chk("w5_ready_ch3", 64'(in_ready5), 64'h08);
        @(posedge clock); #1;
        in_valid5 = '0;
        @(negedge clock);
        chk("w5_next_sel", 64'(out_sel5), 64'd3);
        chk("w5_next_data", 64'(out_data5), 64'h53);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clock);
        @(negedge clock);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
